// File: rtl/app_tx_feeder.sv
// Buffers one packet of 2-byte beats and announces its length to eth_tx before sending it.
// It then replays the packet as full beats followed by one final partial beat.
module app_tx_feeder #(
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int BLOCK_N   = 8,
  parameter int DEPTH     = 64,
  parameter int PKT_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 in_valid_i,
  input  logic [DATA_W-1:0]    in_data_i,
  input  logic [1:0]           in_len_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  input  logic                 abort_i,
  output logic                 err_o,
  output logic                 app_early_v_o,
  input  logic                 app_ready_v_i,
  output logic [PKT_LEN_W-1:0] app_pkt_len_o,
  output logic [DATA_W-1:0]    app_data_o,
  output logic [1:0]           app_len_o,
  output logic                 app_last_o,
  output logic                 app_last_block_next_o,
  output logic [3:0]           app_last_block_next_len_o,
  output logic                 app_cancel_o
);
  localparam int ADDR_W          = $clog2(DEPTH);
  localparam int PTR_W           = ADDR_W + 1;
  localparam int BEATS_PER_BLOCK = BLOCK_N / KEEP_W;

  typedef enum logic [1:0] {FILL, EARLY, SEND, LAST} state_t;
  state_t state_reg, state_next;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PKT_LEN_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [PKT_LEN_W-1:0] pkt_len_reg, pkt_len_next;
  logic [PKT_LEN_W-1:0] rd_idx_reg, rd_idx_next;
  logic                 wr_en, drop, clear, cancel, step, beat_load, last_load;
  logic [ADDR_W-1:0]    rd_addr;
  logic [PKT_LEN_W-1:0] n_full, blk_beat;
  logic [1:0]           rem_len;
  logic [3:0]           blk_len;
  logic [DATA_W-1:0]    data_next;
  logic [1:0]           len_next;
  logic                 last_next, lbn_next;
  logic [3:0]           lbn_len_next;

  assign n_full   = pkt_len_reg / PKT_LEN_W'(KEEP_W);
  assign rem_len  = 2'(pkt_len_reg % PKT_LEN_W'(KEEP_W));
  assign blk_beat = (pkt_len_reg / PKT_LEN_W'(BLOCK_N)) * PKT_LEN_W'(BEATS_PER_BLOCK);
  assign blk_len  = 4'(pkt_len_reg % PKT_LEN_W'(BLOCK_N));
  // rd_idx always equals n_full when the final beat is loaded, so one address serves both
  assign rd_addr  = rd_idx_reg[ADDR_W-1:0];

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    byte_cnt_next = byte_cnt_reg;
    pkt_len_next  = pkt_len_reg;
    rd_idx_next   = rd_idx_reg;
    wr_en         = 1'b0;
    drop          = 1'b0;
    clear         = 1'b0;
    cancel        = 1'b0;
    step          = 1'b0;
    beat_load     = 1'b0;
    last_load     = 1'b0;

    case (state_reg)
      FILL: begin
        if (abort_i) begin
          clear = 1'b1;
        end else if (in_valid_i && in_ready_o) begin
          if (in_len_i > 2'(KEEP_W)) begin
            drop = 1'b1;
          end else if (!in_last_i) begin
            if (in_len_i != 2'(KEEP_W) || wr_ptr_reg == PTR_W'(DEPTH)) begin
              drop = 1'b1;
            end else begin
              wr_en         = 1'b1;
              wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
              byte_cnt_next = byte_cnt_reg + PKT_LEN_W'(in_len_i);
            end
          end else if (in_len_i == 2'd0 && byte_cnt_reg == '0) begin
            // empty packet: nothing to announce, nothing to flag
          end else if (in_len_i != 2'd0 && wr_ptr_reg == PTR_W'(DEPTH)) begin
            drop = 1'b1;
          end else begin
            wr_en        = (in_len_i != 2'd0);
            pkt_len_next = byte_cnt_reg + PKT_LEN_W'(in_len_i);
            state_next   = EARLY;
          end
        end
      end
      EARLY: begin
        if (abort_i) cancel = 1'b1;
        else if (app_early_v_o && app_ready_v_i) step = 1'b1;
      end
      SEND: begin
        if (abort_i) cancel = 1'b1;
        else step = 1'b1;
      end
      LAST: begin
        if (abort_i) cancel = 1'b1;
        else clear = 1'b1;
      end
      default: clear = 1'b1;
    endcase

    if (step) begin
      if (rd_idx_reg < n_full) begin
        beat_load   = 1'b1;
        rd_idx_next = rd_idx_reg + PKT_LEN_W'(1);
        state_next  = SEND;
      end else begin
        last_load  = 1'b1;
        state_next = LAST;
      end
    end

    if (drop || clear || cancel) begin
      state_next    = FILL;
      wr_ptr_next   = '0;
      byte_cnt_next = '0;
      pkt_len_next  = '0;
      rd_idx_next   = '0;
    end

    data_next    = '0;
    len_next     = '0;
    last_next    = 1'b0;
    lbn_next     = 1'b0;
    lbn_len_next = '0;
    if (beat_load) begin
      data_next = mem[rd_addr];
      len_next  = 2'(KEEP_W);
      if (rd_idx_reg == blk_beat && blk_beat < n_full) begin
        lbn_next     = 1'b1;
        lbn_len_next = blk_len;
      end
    end else if (last_load) begin
      last_next = 1'b1;
      len_next  = rem_len;
      if (rem_len != 2'd0) data_next = {{(DATA_W-8){1'b0}}, mem[rd_addr][7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[ADDR_W-1:0]] <= in_data_i;
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state_reg                 <= FILL;
      wr_ptr_reg                <= '0;
      byte_cnt_reg              <= '0;
      pkt_len_reg               <= '0;
      rd_idx_reg                <= '0;
      in_ready_o                <= 1'b0;
      err_o                     <= 1'b0;
      app_cancel_o              <= 1'b0;
      app_early_v_o             <= 1'b0;
      app_pkt_len_o             <= '0;
      app_data_o                <= '0;
      app_len_o                 <= '0;
      app_last_o                <= 1'b0;
      app_last_block_next_o     <= 1'b0;
      app_last_block_next_len_o <= '0;
    end else begin
      state_reg                 <= state_next;
      wr_ptr_reg                <= wr_ptr_next;
      byte_cnt_reg              <= byte_cnt_next;
      pkt_len_reg               <= pkt_len_next;
      rd_idx_reg                <= rd_idx_next;
      in_ready_o                <= (state_next == FILL);
      err_o                     <= drop;
      app_cancel_o              <= cancel;
      app_early_v_o             <= (state_next == EARLY);
      app_pkt_len_o             <= (state_next == FILL) ? '0 : pkt_len_next;
      app_data_o                <= data_next;
      app_len_o                 <= len_next;
      app_last_o                <= last_next;
      app_last_block_next_o     <= lbn_next;
      app_last_block_next_len_o <= lbn_len_next;
    end
  end
endmodule

// File: doc/app_tx_feeder.md
APP_TX_FEEDER -- requirements
Module: app_tx_feeder

Interface
REQ-001 SHALL have parameters: DATA_W 16, data beat width in bits; KEEP_W DATA_W/8, bytes per beat; BLOCK_N 8, bytes per PHY block; DEPTH 64, buffer depth in beats; PKT_LEN_W 16, packet byte-length width.
REQ-002 SHALL have ports: clk in 1, the only clock; nreset in 1, asynchronous active-high reset (1 = in reset).
REQ-003 SHALL have write-side ports: in_valid_i in 1, beat valid; in_data_i in DATA_W, beat bytes LSB-first; in_len_i in 2, valid bytes 0..2; in_last_i in 1, final beat of packet; in_ready_o out 1, beat accepted when in_valid_i & in_ready_o.
REQ-004 SHALL have control ports: abort_i in 1, abandon current packet; err_o out 1, one-cycle pulse when a packet is dropped.
REQ-005 SHALL have eth_tx-facing ports: app_early_v_o out 1, packet pending; app_ready_v_i in 1, eth_tx ready; app_pkt_len_o out PKT_LEN_W, packet bytes; app_data_o out DATA_W, beat data; app_len_o out 2, beat bytes; app_last_o out 1, final beat.
REQ-006 SHALL have further eth_tx-facing ports: app_last_block_next_o out 1, last block starts this beat; app_last_block_next_len_o out 4, bytes in last block; app_cancel_o out 1, packet cancelled.

Function
REQ-007 SHALL implement states FILL, EARLY, SEND, LAST.
REQ-008 FILL: in_ready_o=1; each accepted beat is written at wr_ptr, wr_ptr increments, and byte_cnt increases by in_len_i.
REQ-009 A non-last beat with in_len_i!=2 SHALL drop the packet: err_o pulses, pointers and byte_cnt clear, state stays FILL.
REQ-010 A beat accepted when wr_ptr==DEPTH (overflow, over 128 bytes) SHALL drop the packet the same way as REQ-009.
REQ-011 Accepted in_last_i SHALL latch pkt_len=byte_cnt+in_len_i and move to EARLY next cycle; a zero-length last beat is not stored.
REQ-012 A last beat with in_len_i=0 and byte_cnt=0 SHALL be ignored with no error.
REQ-013 EARLY: app_early_v_o=1 and app_pkt_len_o=pkt_len held stable; in_ready_o=0.
REQ-014 EARLY SHALL move to SEND on the cycle after the first cycle where app_early_v_o & app_ready_v_i.
REQ-015 SEND: N=pkt_len/2 full beats SHALL be presented on consecutive cycles, beat i = buffer[i], app_len_o=2, with no stalls.
REQ-016 SHALL move from SEND to LAST after beat N-1, or directly from EARLY if N=0.
REQ-017 app_last_block_next_o=1 with app_last_block_next_len_o=pkt_len%8 SHALL be driven only on full beat i=4*(pkt_len/8), and only if that i<N.
REQ-018 app_last_block_next_len_o SHALL be 0 whenever app_last_block_next_o=0.
REQ-019 LAST: a single beat SHALL be driven with app_last_o=1 and app_len_o=pkt_len%2 (0 allowed); app_data_o = buffer[N] when the length is 1, else 0.
REQ-020 After LAST the block SHALL return to FILL with pointers and byte_cnt cleared.
REQ-021 When app_len_o=1, app_data_o[15:8] SHALL be 0.
REQ-022 Outside SEND/LAST, app_data_o, app_len_o and app_last_o SHALL be 0.
REQ-023 abort_i in EARLY/SEND/LAST SHALL pulse app_cancel_o for 1 cycle next cycle, deassert all other app_* outputs that cycle, and return to FILL cleared.
REQ-024 abort_i in FILL SHALL clear the partial packet without err_o.
REQ-025 When abort_i coincides with in_last_i acceptance, abort_i SHALL win: packet dropped, no EARLY.
REQ-026 Output latency SHALL be registered: all outputs are flop outputs, with no combinational path from app_ready_v_i to app outputs.

Reset
REQ-027 While nreset=1, state SHALL be FILL, pointers/byte_cnt/pkt_len SHALL be 0, and every output 0 except in_ready_o.
REQ-028 in_ready_o SHALL be 0 during reset and 1 from the first clk edge after release.
REQ-029 nreset assertion mid-SEND SHALL discard the packet without an app_cancel_o pulse.

Verification
REQ-030 12-byte packet (6 beats len 2, last len 2), app_ready_v_i=1 -> early 1 cycle, pkt_len 12, 6 beats len 2, last_block_next on beat 4 with len 4, then last beat len 0.
REQ-031 13-byte packet -> 6 full beats, last_block_next on beat 4 with len 5, last beat len 1 with byte 12 in [7:0] and [15:8]=0.
REQ-032 16-byte packet -> 8 full beats, last_block_next never asserted, last beat len 0.
REQ-033 app_ready_v_i low 5 cycles in EARLY -> early held 5 cycles with pkt_len stable; beat 0 appears the cycle after ready is seen.
REQ-034 Non-last beat len 1 -> err_o one pulse, no early; 130-byte packet -> err_o on overflow beat.
REQ-035 abort_i on beat 2 of SEND -> app_cancel_o one pulse, next packet sent intact.
